// File: rtl/wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wb_mem_arbiter
//
// Shares one Wishbone classic master port between NUM_M RV32I data-memory
// interfaces. Requests are arbitrated round-robin and served one at a time;
// cores that are not being served see m_ready=0 and stall. A watchdog ends a
// bus cycle that never gets ack/err, so a dead slave cannot hang a core.
//
// Transaction flow (one bus cycle per transaction):
//   IDLE : pick a requester, latch its addr/we/wdata/be into the wb_* outputs
//   BUS  : cyc=stb=1 until ack, err or watchdog expiry
//   DONE : one-cycle m_ready pulse to the granted core, bus_err on err/timeout
//
// Parameters
//   NUM_M    number of requesting cores (2..8)
//   TIMEOUT  max BUS cycles without ack/err before the cycle is aborted
//            (1..65535)
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   m_req/m_we          per-core request / write strobe          [NUM_M]
//   m_addr/m_wdata      per-core address / store data, 32 b each  [32*NUM_M]
//   m_be                per-core byte enables, 4 b each           [4*NUM_M]
//   m_ready             per-core completion pulse                 [NUM_M]
//   m_rdata             read data, valid while any m_ready bit is high
//   wb_*_o / wb_*_i     Wishbone classic master port
//   bus_err             one-cycle pulse with m_ready on err or timeout
//   grant_id            index of the current or last granted core (debug)
// -----------------------------------------------------------------------------
module wb_mem_arbiter #(
  parameter int NUM_M   = 2,
  parameter int TIMEOUT = 255,
  localparam int GW     = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic [NUM_M-1:0]     m_req,
  input  logic [NUM_M-1:0]     m_we,
  input  logic [32*NUM_M-1:0]  m_addr,
  input  logic [32*NUM_M-1:0]  m_wdata,
  input  logic [4*NUM_M-1:0]   m_be,
  output logic [NUM_M-1:0]     m_ready,
  output logic [31:0]          m_rdata,

  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [31:0]          wb_adr_o,
  output logic [31:0]          wb_dat_o,
  output logic [3:0]           wb_sel_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,

  output logic                 bus_err,
  output logic [GW-1:0]        grant_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [GW-1:0] RR_INIT = GW'(NUM_M - 1);

  state_t          state;
  state_t          state_nx;

  // Round-robin pointer: the last granted core; search starts just above it.
  logic [GW-1:0]   rr;
  logic [15:0]     tmo_cnt;

  logic            pick_vld;
  logic [GW-1:0]   pick;

  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic [3:0]      sel_be;
  logic            sel_we;

  logic            tmo_hit;
  logic            bus_end;
  logic [NUM_M-1:0] gnt_onehot;

  // ---------------------------------------------------------------------------
  // Round-robin pick. Two candidates are tracked in one pass: the lowest
  // requester strictly above rr, and the lowest requester overall. The first
  // one wins; the second covers the wrap-around case. Scanning downward lets
  // the last hit in the loop be the lowest index.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic          hi_hit;
    logic [GW-1:0] hi_idx;
    logic          lo_hit;
    logic [GW-1:0] lo_idx;

    hi_hit = 1'b0;
    hi_idx = '0;
    lo_hit = 1'b0;
    lo_idx = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (m_req[i]) begin
        lo_hit = 1'b1;
        lo_idx = GW'(i);
        if (GW'(i) > rr) begin
          hi_hit = 1'b1;
          hi_idx = GW'(i);
        end
      end
    end
    pick_vld = lo_hit;
    pick     = hi_hit ? hi_idx : lo_idx;
  end

  // Request fields of the picked core.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (pick == GW'(i)) begin
        sel_addr  = m_addr[32*i +: 32];
        sel_wdata = m_wdata[32*i +: 32];
        sel_be    = m_be[4*i +: 4];
        sel_we    = m_we[i];
      end
    end
  end

  // Completion pulse target.
  always_comb begin
    gnt_onehot = '0;
    for (int i = 0; i < NUM_M; i++) begin
      gnt_onehot[i] = (grant_id == GW'(i));
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);
  assign bus_end = wb_ack_i || wb_err_i || tmo_hit;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM: next-state logic. Stray ack/err outside BUS never moves the FSM.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (pick_vld) state_nx = S_BUS;
      S_BUS:   if (bus_end)  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from the state register (glitch-free, no ack path).
  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    if (state == S_BUS) begin
      wb_cyc_o = 1'b1;
      wb_stb_o = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture (IDLE -> BUS) and response capture (BUS -> DONE).
  // m_ready/bus_err/m_rdata are registered on the BUS->DONE edge, so a core
  // sees completion one cycle after the slave's ack.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr       <= RR_INIT;
      grant_id <= '0;
      tmo_cnt  <= '0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      m_ready  <= '0;
      m_rdata  <= '0;
      bus_err  <= 1'b0;
    end else begin
      m_ready <= '0;
      bus_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant_id <= pick;
            rr       <= pick;
            wb_we_o  <= sel_we;
            wb_adr_o <= sel_addr;
            wb_dat_o <= sel_wdata;
            wb_sel_o <= sel_be;
          end
        end
        S_BUS: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (bus_end) begin
            m_ready <= gnt_onehot;
            // Ack has priority: a simultaneous err is not reported.
            m_rdata <= wb_ack_i ? wb_dat_i : 32'h0;
            bus_err <= !wb_ack_i;
          end
        end
        S_DONE: begin
          tmo_cnt <= '0;
        end
        default: begin
          tmo_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
module tb_wb_mem_arbiter;

  localparam int NUM_M   = 3;
  localparam int TIMEOUT = 8;
  localparam int GW      = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_M-1:0]     m_req = '0;
  logic [NUM_M-1:0]     m_we = '0;
  logic [32*NUM_M-1:0]  m_addr = '0;
  logic [32*NUM_M-1:0]  m_wdata = '0;
  logic [4*NUM_M-1:0]   m_be = '0;
  logic [NUM_M-1:0]     m_ready;
  logic [31:0]          m_rdata;
  logic                 wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]          wb_adr_o, wb_dat_o;
  logic [3:0]           wb_sel_o;
  logic [31:0]          wb_dat_i = '0;
  logic                 wb_ack_i = 1'b0;
  logic                 wb_err_i = 1'b0;
  logic                 bus_err;
  logic [GW-1:0]        grant_id;

  wb_mem_arbiter #(.NUM_M(NUM_M), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .bus_err(bus_err), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one transaction at a time. A transaction is opened when
  // the arbiter is free and some core requests, lives for a number of bus
  // cycles, and is followed by exactly one completion cycle.
  // ---------------------------------------------------------------------------
  bit               mdl_busy = 1'b0;
  bit               mdl_done = 1'b0;
  int               mdl_age  = 0;
  int               mdl_rr   = NUM_M - 1;
  logic             exp_cyc  = 1'b0;
  logic             exp_we   = 1'b0;
  logic [31:0]      exp_adr  = '0;
  logic [31:0]      exp_dat  = '0;
  logic [3:0]       exp_sel  = '0;
  logic [NUM_M-1:0] exp_ready = '0;
  logic [31:0]      exp_rdata = '0;
  logic             exp_err  = 1'b0;
  int               exp_gid  = 0;

  always @(posedge clk) begin
    int  c;
    bit  found;
    exp_ready = '0;
    exp_err   = 1'b0;
    if (!rst_n) begin
      mdl_busy = 0; mdl_done = 0; mdl_age = 0; mdl_rr = NUM_M - 1;
      exp_cyc = 0; exp_we = 0; exp_adr = 0; exp_dat = 0; exp_sel = 0;
      exp_rdata = 0; exp_gid = 0;
    end else if (mdl_busy) begin
      mdl_age++;
      if (wb_ack_i || wb_err_i || mdl_age == TIMEOUT) begin
        mdl_busy = 0;
        mdl_done = 1;
        exp_cyc  = 0;
        exp_ready[exp_gid] = 1'b1;
        exp_rdata = wb_ack_i ? wb_dat_i : 32'h0;
        exp_err   = !wb_ack_i;
      end
    end else if (mdl_done) begin
      mdl_done = 0;
    end else if (m_req != '0) begin
      found = 0;
      for (int k = 1; k <= NUM_M; k++) begin
        c = (mdl_rr + k) % NUM_M;
        if (!found && m_req[c]) begin
          found   = 1;
          exp_gid = c;
        end
      end
      mdl_rr   = exp_gid;
      mdl_busy = 1;
      mdl_age  = 0;
      exp_cyc  = 1;
      exp_we   = m_we[exp_gid];
      exp_adr  = m_addr[32*exp_gid +: 32];
      exp_dat  = m_wdata[32*exp_gid +: 32];
      exp_sel  = m_be[4*exp_gid +: 4];
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("cyc",     32'(wb_cyc_o),  32'(exp_cyc));
    check("stb",     32'(wb_stb_o),  32'(exp_cyc));
    check("we",      32'(wb_we_o),   32'(exp_we));
    check("adr",     wb_adr_o,       exp_adr);
    check("dat_o",   wb_dat_o,       exp_dat);
    check("sel",     32'(wb_sel_o),  32'(exp_sel));
    check("m_ready", 32'(m_ready),   32'(exp_ready));
    check("bus_err", 32'(bus_err),   32'(exp_err));
    check("grant",   32'(grant_id),  32'(exp_gid));
    if (exp_ready != '0) check("m_rdata", m_rdata, exp_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    m_req[i] = 1'b1;
    m_we[i]  = we;
    m_addr[32*i +: 32]  = a;
    m_wdata[32*i +: 32] = d;
    m_be[4*i +: 4]      = be;
  endtask

  task automatic wait_ready(input int lim);
    bit ok;
    ok = 0;
    for (int n = 0; n < lim && !ok; n++) begin
      if (m_ready != '0) ok = 1;
      else tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_ready: no m_ready within %0d cycles", lim);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int mode;
    int seq [4];
    seq = '{0, 1, 2, 0};

    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    check("rst_cyc",   32'(wb_cyc_o), 32'h0);
    check("rst_ready", 32'(m_ready),  32'h0);
    check("rst_adr",   wb_adr_o,      32'h0);
    check("rst_err",   32'(bus_err),  32'h0);
    check("rst_rdata", m_rdata,       32'h0);

    // Single read, ack in the second bus cycle
    set_core(0, 1'b0, 32'h100, 32'h0, 4'hF);
    tick();
    check("rd_cyc", 32'(wb_cyc_o), 32'h1);
    check("rd_adr", wb_adr_o,      32'h100);
    check("rd_sel", 32'(wb_sel_o), 32'hF);
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D;
    tick();
    check("rd_ready", 32'(m_ready), 32'h1);
    check("rd_rdata", m_rdata,      32'hCAFEF00D);
    check("rd_cyc_done", 32'(wb_cyc_o), 32'h0);
    m_req = '0; wb_ack_i = 1'b0;
    tick();
    check("rd_pulse", 32'(m_ready), 32'h0);

    // Write, immediate ack
    set_core(1, 1'b1, 32'h204, 32'h12345678, 4'b0011);
    tick();
    wb_ack_i = 1'b1;
    check("wr_we",  32'(wb_we_o),  32'h1);
    check("wr_dat", wb_dat_o,      32'h12345678);
    check("wr_sel", 32'(wb_sel_o), 32'h3);
    check("wr_adr", wb_adr_o,      32'h204);
    tick();
    check("wr_ready", 32'(m_ready), 32'h2);
    check("wr_err",   32'(bus_err), 32'h0);
    m_req = '0; wb_ack_i = 1'b0;
    tick();

    // Slave error
    set_core(2, 1'b0, 32'h300, 32'h0, 4'hF);
    tick();
    wb_err_i = 1'b1; wb_dat_i = 32'hDEADBEEF;
    tick();
    check("err_ready", 32'(m_ready), 32'h4);
    check("err_rdata", m_rdata,      32'h0);
    check("err_flag",  32'(bus_err), 32'h1);
    m_req = '0; wb_err_i = 1'b0;
    tick();

    // Timeout: no ack, cyc held for exactly TIMEOUT cycles
    set_core(0, 1'b0, 32'h400, 32'h0, 4'hF);
    tick();
    n = 0;
    while (wb_cyc_o && n < 50) begin
      n++;
      tick();
    end
    check("tmo_len",   32'(n),         32'd8);
    check("tmo_ready", 32'(m_ready),   32'h1);
    check("tmo_flag",  32'(bus_err),   32'h1);
    check("tmo_rdata", m_rdata,        32'h0);
    m_req = '0;
    tick();

    // Contention: all cores request continuously, slave acks at once
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < NUM_M; i++) set_core(i, 1'b0, 32'h1000 + 32'(i), 32'h0, 4'hF);
    wb_ack_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_ready(10);
      check("cont_order", 32'(m_ready), 32'(1) << seq[t]);
      if (t == 3) m_req = '0;
      tick();
      check("cont_pulse", 32'(m_ready), 32'h0);
    end
    wb_ack_i = 1'b0;
    tick();

    // Reset in the middle of a bus cycle
    set_core(1, 1'b0, 32'h500, 32'h0, 4'hF);
    tick();
    check("rbus_cyc", 32'(wb_cyc_o), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rbus_cyc0",  32'(wb_cyc_o), 32'h0);
    check("rbus_stb0",  32'(wb_stb_o), 32'h0);
    check("rbus_ready", 32'(m_ready),  32'h0);
    set_core(0, 1'b0, 32'h600, 32'h0, 4'hF);
    tick();
    check("rbus_grant", 32'(grant_id), 32'h0);
    wb_ack_i = 1'b1;
    tick();
    check("rbus_done", 32'(m_ready), 32'h1);
    m_req = '0; wb_ack_i = 1'b0;
    tick();

    // Randomized traffic
    mode = 0;
    for (int cyc_i = 0; cyc_i < 3000; cyc_i++) begin
      if (cyc_i % 50 == 0) mode = int'($urandom_range(0, 2));
      wb_dat_i = $urandom;
      case (mode)
        0: begin
          wb_ack_i = ($urandom_range(0, 1) == 1);
          wb_err_i = ($urandom_range(0, 9) == 0);
        end
        1: begin
          wb_ack_i = 1'b0;
          wb_err_i = 1'b0;
        end
        default: begin
          wb_ack_i = ($urandom_range(0, 3) == 0);
          wb_err_i = ($urandom_range(0, 3) == 0);
        end
      endcase
      for (int i = 0; i < NUM_M; i++) begin
        if (m_ready[i] || !m_req[i]) begin
          if ($urandom_range(0, 2) != 0)
            set_core(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
          else
            m_req[i] = 1'b0;
        end
      end
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1;
    m_req = '0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Shares one Wishbone classic master port between NUM_M RV32I data-memory interfaces (mem_req/mem_we/mem_addr/mem_wdata/mem_be/mem_ready/mem_rdata).
- Arbitration is round-robin. The block runs one transaction at a time and holds the losing cores stalled via mem_ready=0.
- A watchdog aborts bus cycles that receive no ack, so a dead slave cannot hang a core.
- Sits between the core cluster and the NoC/Wishbone interconnect.

Parameters:
- NUM_M, 2, number of requesting cores (2..8).
- TIMEOUT, 255, max cycles in BUS without ack/err before abort (1..65535).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- m_req  in  NUM_M  per-core mem_req.
- m_we  in  NUM_M  per-core mem_we.
- m_addr  in  32*NUM_M  per-core mem_addr; core i at bits [32i+31:32i].
- m_wdata  in  32*NUM_M  per-core store data, same packing.
- m_be  in  4*NUM_M  per-core byte enables; core i at [4i+3:4i].
- m_ready  out  NUM_M  per-core mem_ready; one-cycle pulse.
- m_rdata  out  32  read data, shared by all cores; valid while any m_ready bit is high.
- wb_cyc_o  out  1  Wishbone CYC.
- wb_stb_o  out  1  Wishbone STB.
- wb_we_o  out  1  Wishbone WE.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_sel_o  out  4  Wishbone SEL.
- wb_dat_i  in  32  Wishbone read data.
- wb_ack_i  in  1  Wishbone ACK.
- wb_err_i  in  1  Wishbone ERR.
- bus_err  out  1  one-cycle pulse on err or timeout completion.
- grant_id  out  clog2(NUM_M)  index of the current or last granted core (debug).

Behaviour:
- Reset (rst_n=0 at an edge): all outputs 0, FSM=IDLE, rr pointer=NUM_M-1, timeout counter=0. Applies mid-transaction too: the bus cycle is dropped and no m_ready is issued.
- FSM states: IDLE, BUS, DONE.
- IDLE, any m_req set:
  - Grant the first requester found searching from (rr+1) mod NUM_M upward with wrap.
  - Register that core's addr/we/wdata/be into the wb_*_o outputs.
  - Set rr=grant_id, go to BUS.
- IDLE, no request: stay; cyc=stb=0.
- BUS:
  - cyc=stb=1; adr/dat/sel/we held constant.
  - Timeout counter increments each cycle.
  - On ack_i or err_i: go to DONE. Capture rdata = ack ? wb_dat_i : 32'h0 (ack has priority if both are high).
  - When counter reaches TIMEOUT-1 with no ack/err: go to DONE, rdata=0, flag error.
- DONE:
  - cyc=stb=0.
  - m_ready[grant_id]=1 for exactly this cycle; m_rdata=captured value.
  - bus_err=1 if err or timeout occurred.
  - Clear counter, return to IDLE.
- m_ready is registered, never combinational from ack. A core sees it one cycle after ack.
- Minimum latency from m_req rise to m_ready: 3 cycles (IDLE sample → BUS with same-cycle ack → DONE).
- The req line sampled in the cycle after DONE belongs to the core's next instruction and is treated as a new request. Back-to-back requests from one core each take ≥3 cycles.
- Fairness: with all cores requesting continuously, grants rotate 0,1,..,NUM_M-1,0. No core waits more than NUM_M transactions.
- m_req dropped by a core during BUS: the transaction still completes and m_ready still pulses. Cores must not do this.
- m_req of non-granted cores is ignored until IDLE. Their m_ready stays 0, so they stall.
- Stores: m_rdata=0 unless slave data is returned; cores ignore it on writes.
- Stray ack_i/err_i in IDLE or DONE: ignored.

Test Plan:
- Single read: core0 req addr 0x100, slave acks 2 cycles after stb with 0xCAFEF00D → adr_o=0x100, sel from m_be; m_ready[0] is a 1-cycle pulse, m_rdata=0xCAFEF00D; total latency 4 cycles.
- Write: core1 we=1, addr 0x204, wdata 0x12345678, be 4'b0011, immediate ack → wb_we_o=1, dat_o=0x12345678, sel=0011; m_ready[1] pulses 3 cycles after req.
- Contention, NUM_M=2: both cores hold req, slave acks immediately → grants alternate 0,1,0,1 over 4 transactions; each m_ready pulses in order, never simultaneously.
- Error: slave asserts err_i → m_ready pulses with m_rdata=0 and bus_err=1 in the same cycle.
- Timeout with TIMEOUT=8: no ack → cyc high for exactly 8 cycles, then m_ready and bus_err pulse, m_rdata=0.
- Reset mid-BUS: rst_n=0 for one edge → next cycle cyc=stb=0, m_ready=0; the next grant starts from core 0.
